// File: rtl/spi_sd_pkg.sv
// Shared definitions for the SD-card-side SPI front end.
// Holds frame geometry, CRC7 polynomial, frame bit positions and the
// command receiver state encoding. No ports (package).
package spi_sd_pkg;

  localparam int FRAME_BITS = 48;
  localparam int ARG_W      = 32;
  localparam int IDX_W      = 6;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Bit positions within the 48-bit frame (bit 47 is sent first).
  localparam int START_POS = 47;
  localparam int TX_POS    = 46;
  localparam int IDX_MSB   = 45;
  localparam int ARG_MSB   = 39;
  localparam int CRC_MSB   = 7;
  localparam int END_POS   = 0;

  // Counter value when the final (end) bit is sampled, and the last
  // counter value whose bit still feeds the CRC (frame bit 8).
  localparam logic [5:0] LAST_CNT     = 6'(FRAME_BITS - 1);
  localparam logic [5:0] CRC_LAST_CNT = 6'(START_POS - 8);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // One serial CRC7 step, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc,
                                           input logic       din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator (x^7 + x^3 + 1, init 0), MSB-first.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart from zero; when enable is also high the current
//                bit is folded into the fresh (zero) value
//   enable     : fold bit_in into the accumulator this edge
//   bit_in     : serial data bit
//   crc        : current 7-bit CRC value
module sd_crc7
  import spi_sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] base;

  assign base = clear ? 7'h00 : crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= crc7_step(base, bit_in);
    end else if (clear) begin
      crc <= 7'h00;
    end
  end

endmodule

// File: rtl/spi_cmd_receiver.sv
// SD SPI command receiver: deserialises 48-bit command frames from MOSI
// (sampled on rising CLK, SPI mode 0) once the card is initialised,
// checks framing and optionally CRC7, and presents index/argument.
//
// Ports:
//   CLK           : host SPI clock
//   reset         : asynchronous active-high reset
//   MOSI          : serial data, MSB first
//   CS            : chip select, active low; high during a frame aborts it
//   IsInitialized : gates new frame starts
//   cmd_valid     : one-cycle pulse, good framing; qualifies the fields below
//   cmd_index     : frame bits [45:40]
//   cmd_arg       : frame bits [39:8]
//   crc_ok        : received CRC7 matches computed CRC7
//   frame_error   : one-cycle pulse, bad transmission or end bit
//   busy          : high while in SHIFT
//
// Build option: define SPI_CMD_CRC_CHECK_EN to build the CRC7 checker.
// Without it no CRC logic exists and every good frame reports crc_ok = 1.
//
// Handshake: there is no back-pressure. cmd_valid and frame_error are
// single-cycle strobes; cmd_index/cmd_arg/crc_ok are stable from the
// cmd_valid cycle until the next good frame.
module spi_cmd_receiver
  import spi_sd_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic             MOSI,
  input  logic             CS,
  input  logic             IsInitialized,
  output logic             cmd_valid,
  output logic [IDX_W-1:0] cmd_index,
  output logic [ARG_W-1:0] cmd_arg,
  output logic             crc_ok,
  output logic             frame_error,
  output logic             busy
);

  state_t     state, state_next;
  logic [5:0] cnt;

  // The start bit is always 0 and is never needed after detection, so only
  // frame bits 46..1 are retained; frame bit k lives at shreg[k-1] when the
  // end bit is on MOSI.
  logic [FRAME_BITS-3:0] shreg;

  logic start, last_bit, abort;
  logic frame_good, crc_match;
  logic [6:0] rx_crc;

  assign rx_crc     = shreg[CRC_MSB-1 -: 7];
  assign frame_good = shreg[TX_POS-1] & MOSI;
  assign busy       = (state == SHIFT);

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    last_bit   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (IsInitialized && !CS && !MOSI) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (CS) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (cnt == LAST_CNT) begin
          last_bit   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- CRC ----------------
`ifdef SPI_CMD_CRC_CHECK_EN
  logic       crc_en;
  logic [6:0] crc_val;

  // The start bit seeds the accumulator; frame bits 46..8 follow.
  assign crc_en = start | (busy && !CS && (cnt <= CRC_LAST_CNT));

  sd_crc7 u_crc7 (
    .clk    (CLK),
    .rst    (reset),
    .clear  (start),
    .enable (crc_en),
    .bit_in (MOSI),
    .crc    (crc_val)
  );

  assign crc_match = (crc_val == rx_crc);
`else
  logic unused_rx_crc;
  assign unused_rx_crc = ^rx_crc;
  assign crc_match     = 1'b1;
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      shreg       <= '0;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
      crc_ok      <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;

      if (start) begin
        cnt   <= 6'd1;
        shreg <= '0;
      end else if (abort) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (busy) begin
        shreg <= {shreg[FRAME_BITS-4:0], MOSI};
        cnt   <= last_bit ? 6'd0 : cnt + 6'd1;
      end

      if (last_bit) begin
        if (frame_good) begin
          cmd_valid <= 1'b1;
          cmd_index <= shreg[IDX_MSB-1 -: IDX_W];
          cmd_arg   <= shreg[ARG_MSB-1 -: ARG_W];
          crc_ok    <= crc_match;
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_receiver.sv
module tb_spi_cmd_receiver;

  logic        CLK = 1'b0;
  logic        reset;
  logic        MOSI;
  logic        CS;
  logic        IsInitialized;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        crc_ok;
  logic        frame_error;
  logic        busy;

`ifdef SPI_CMD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  localparam logic [47:0] F_CMD0    = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8    = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_BADCRC  = 48'h48_0000_01AA_FF;
  localparam logic [47:0] F_BADEND  = 48'h40_0000_0000_94;
  localparam logic [47:0] F_BADTX   = 48'h00_0000_0000_95;

  spi_cmd_receiver dut (
    .CLK           (CLK),
    .reset         (reset),
    .MOSI          (MOSI),
    .CS            (CS),
    .IsInitialized (IsInitialized),
    .cmd_valid     (cmd_valid),
    .cmd_index     (cmd_index),
    .cmd_arg       (cmd_arg),
    .crc_ok        (crc_ok),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // {crc_ok, cmd_index, cmd_arg}
  logic [38:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc        = 0;
  int n_valid    = 0;
  int n_ferr     = 0;
  int last_vcyc  = 0;
  int prev_vcyc  = 0;
  bit busy_seen  = 1'b0;

  always @(negedge CLK) begin
    logic [38:0] e;
    cyc++;
    if (busy) busy_seen = 1'b1;
    if (frame_error) n_ferr++;
    if (cmd_valid) begin
      n_valid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_cmd_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("cmd_index", 64'(cmd_index), 64'(e[37:32]));
        check("cmd_arg",   64'(cmd_arg),   64'(e[31:0]));
        check("crc_ok",    64'(crc_ok),    64'(e[38]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      MOSI = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [47:0] f, input int nbits);
    for (int i = 47; i > 47 - nbits; i--) begin
      @(negedge CLK);
      MOSI = f[i];
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    send_bits(f, 48);
  endtask

  task automatic expect_frame(input logic ok, input logic [5:0] idx,
                              input logic [31:0] arg);
    exp_q.push_back({ok, idx, arg});
  endtask

  // ---------------- stimulus ----------------
  int v0, e0;

  initial begin
    reset         = 1'b1;
    MOSI          = 1'b1;
    CS            = 1'b1;
    IsInitialized = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cmd_valid",   64'(cmd_valid),   64'd0);
    check("rst_frame_error", 64'(frame_error), 64'd0);
    check("rst_busy",        64'(busy),        64'd0);
    check("rst_cmd_index",   64'(cmd_index),   64'd0);
    check("rst_cmd_arg",     64'(cmd_arg),     64'd0);
    check("rst_crc_ok",      64'(crc_ok),      64'd0);
    reset = 1'b0;
    idle(2);

    // Gating: not initialised, frame must be ignored.
    CS = 1'b0;
    busy_seen = 1'b0;
    v0 = n_valid; e0 = n_ferr;
    send_frame(F_CMD0);
    idle(3);
    check("gate_no_valid", 64'(n_valid - v0), 64'd0);
    check("gate_no_ferr",  64'(n_ferr - e0),  64'd0);
    check("gate_busy",     64'(busy_seen),    64'd0);

    // CMD0 then CMD8 back-to-back.
    IsInitialized = 1'b1;
    v0 = n_valid;
    expect_frame(1'b1, 6'd0, 32'h0000_0000);
    expect_frame(1'b1, 6'd8, 32'h0000_01AA);
    send_frame(F_CMD0);
    send_frame(F_CMD8);
    idle(3);
    check("b2b_valid_count", 64'(n_valid - v0),          64'd2);
    check("b2b_spacing",     64'(last_vcyc - prev_vcyc), 64'd48);
    check("valid_pulse_low", 64'(cmd_valid),             64'd0);

    // Bad CRC: framing fine, CRC result depends on the build.
    v0 = n_valid;
    expect_frame(!CRC_EN, 6'd8, 32'h0000_01AA);
    send_frame(F_BADCRC);
    idle(3);
    check("badcrc_valid", 64'(n_valid - v0), 64'd1);

    // Bad end bit: frame_error, fields hold.
    v0 = n_valid; e0 = n_ferr;
    send_frame(F_BADEND);
    idle(3);
    check("badend_ferr",     64'(n_ferr - e0),  64'd1);
    check("badend_no_valid", 64'(n_valid - v0), 64'd0);
    check("badend_idx_hold", 64'(cmd_index),    64'd8);
    check("badend_arg_hold", 64'(cmd_arg),      64'h1AA);
    check("badend_crc_hold", 64'(crc_ok),       64'(!CRC_EN));

    // Bad transmission bit.
    v0 = n_valid; e0 = n_ferr;
    send_frame(F_BADTX);
    idle(3);
    check("badtx_ferr",     64'(n_ferr - e0),  64'd1);
    check("badtx_no_valid", 64'(n_valid - v0), 64'd0);

    // CS abort after 20 bits, then a full CMD0.
    v0 = n_valid; e0 = n_ferr;
    send_bits(F_CMD0, 20);
    @(negedge CLK);
    check("abort_busy_before", 64'(busy), 64'd1);
    CS   = 1'b1;
    MOSI = 1'b1;
    @(negedge CLK);
    check("abort_busy_after", 64'(busy), 64'd0);
    CS = 1'b0;
    expect_frame(1'b1, 6'd0, 32'h0000_0000);
    send_frame(F_CMD0);
    idle(3);
    check("abort_valid_count", 64'(n_valid - v0), 64'd1);
    check("abort_no_ferr",     64'(n_ferr - e0),  64'd0);

    // Reset at bit 30 of a CMD8, then a full CMD8.
    v0 = n_valid;
    send_bits(F_CMD8, 30);
    @(posedge CLK);
    #2;
    check("midrst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy",        64'(busy),        64'd0);
    check("midrst_cmd_valid",   64'(cmd_valid),   64'd0);
    check("midrst_frame_error", 64'(frame_error), 64'd0);
    check("midrst_cmd_index",   64'(cmd_index),   64'd0);
    check("midrst_cmd_arg",     64'(cmd_arg),     64'd0);
    check("midrst_crc_ok",      64'(crc_ok),      64'd0);
    @(negedge CLK);
    reset = 1'b0;
    MOSI  = 1'b1;
    expect_frame(1'b1, 6'd8, 32'h0000_01AA);
    send_frame(F_CMD8);
    idle(3);
    check("midrst_valid_count", 64'(n_valid - v0), 64'd1);
    check("midrst_idx_held",    64'(cmd_index),    64'd8);

    idle(2);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
